rr_write_arbiter: RTL and testbench

//   Shares one synchronous-reset data register (DATA_W flops) between N_REQ requesters.

---
 rtl/rr_write_arbiter.sv | 138 +++++++++++++
 tb/tb_rr_write_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rr_write_arbiter.sv
// rr_write_arbiter: round-robin owner selection for a single shared data register.
// The current owner streams beats into q. A burst ends on an explicit last
// beat, when the owner drops req, or when MAX_BURST beats have been taken.
// gnt is registered, so each new grant is preceded by one idle cycle.
module rr_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          last,
  input  logic [N_REQ*DATA_W-1:0]   wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [$clog2(N_REQ)-1:0]  owner,
  output logic [DATA_W-1:0]         q,
  output logic                      q_valid
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]        state_reg, state_next;
  logic [N_REQ-1:0]  gnt_reg, gnt_next;
  logic [PTR_W-1:0]  owner_reg, owner_next;
  logic [PTR_W-1:0]  ptr_reg, ptr_next;
  logic [CNT_W-1:0]  beat_cnt_reg, beat_cnt_next;
  logic [DATA_W-1:0] q_reg, q_next;
  logic              q_valid_reg, q_valid_next;

  // Per-requester view of the flat write-data bus.
  logic [DATA_W-1:0] wdata_arr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign wdata_arr[gi] = wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Round-robin search: the first asserted req starting at ptr wins.
  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] cand_idx;

  // Scan from the far end back toward ptr so the closest candidate is kept last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand_idx = PTR_W'((int'(ptr_reg) + k) % N_REQ);
      if (req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Beat and release decode for the current owner; only meaningful while BUSY.
  logic busy;
  logic beat;
  logic cnt_hit;
  logic release_now;

  assign busy        = (state_reg == BUSY);
  assign beat        = busy && req[owner_reg];
  assign cnt_hit     = (({1'b0, beat_cnt_reg} + {{CNT_W{1'b0}}, 1'b1}) == (CNT_W+1)'(MAX_BURST));
  assign release_now = busy && (!req[owner_reg] || last[owner_reg] || cnt_hit);

  // Next-state logic for the arbiter FSM and the shared data register.
  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    owner_next    = owner_reg;
    ptr_next      = ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    q_next        = q_reg;
    q_valid_next  = beat;

    if (beat) begin
      q_next        = wdata_arr[owner_reg];
      beat_cnt_next = beat_cnt_reg + 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next    = BUSY;
          gnt_next      = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          owner_next    = win_idx;
          beat_cnt_next = '0;
        end
      end
      BUSY: begin
        if (release_now) begin
          state_next = IDLE;
          gnt_next   = '0;
          ptr_next   = (owner_reg == PTR_W'(N_REQ - 1)) ? '0 : owner_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  // State registers; reset overrides any in-flight beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      owner_reg    <= '0;
      ptr_reg      <= '0;
      beat_cnt_reg <= '0;
      q_reg        <= '0;
      q_valid_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      owner_reg    <= owner_next;
      ptr_reg      <= ptr_next;
      beat_cnt_reg <= beat_cnt_next;
      q_reg        <= q_next;
      q_valid_reg  <= q_valid_next;
    end
  end

  assign gnt     = gnt_reg;
  assign owner   = owner_reg;
  assign q       = q_reg;
  assign q_valid = q_valid_reg;

endmodule

// File: tb/tb_rr_write_arbiter.sv
// tb_rr_write_arbiter: directed scenarios plus randomized traffic, compared
// every cycle against a behavioural round-robin model.
module tb_rr_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req;
  logic [N-1:0]    last;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt;
  logic [1:0]      owner;
  logic [DW-1:0]   q;
  logic            q_valid;

  int checks = 0;
  int errors = 0;

  rr_write_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .last    (last),
    .wdata   (wdata),
    .gnt     (gnt),
    .owner   (owner),
    .q       (q),
    .q_valid (q_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: plain integers and a busy flag.
  bit m_busy;
  int m_owner, m_ptr, m_cnt, m_q, m_qv, m_gnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one clock edge's worth of arbitration rules to the model.
  task automatic model_edge();
    int slice;
    bit taken;
    if (reset) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_q = 0; m_qv = 0; m_gnt = 0;
    end else if (!m_busy) begin
      m_qv = 0;
      for (int k = 0; k < N; k++) begin
        slice = (m_ptr + k) % N;
        if (req[slice]) begin
          m_busy = 1; m_owner = slice; m_gnt = 1 << slice; m_cnt = 0;
          break;
        end
      end
    end else begin
      taken = req[m_owner];
      if (taken) begin
        m_q  = int'(wdata[m_owner*DW +: DW]);
        m_qv = 1;
        m_cnt++;
      end else begin
        m_qv = 0;
      end
      if (!taken || last[m_owner] || m_cnt == MB) begin
        m_busy = 0; m_gnt = 0; m_ptr = (m_owner + 1) % N;
      end
    end
  endtask

  // Drive inputs, take one edge, then compare all outputs with the model.
  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] ls,
                      input logic [N*DW-1:0] wd);
    reset = r; req = rq; last = ls; wdata = wd;
    @(posedge clk);
    model_edge();
    #1;
    chk("m_gnt",   32'(gnt),     32'(m_gnt));
    chk("m_owner", 32'(owner),   32'(m_owner));
    chk("m_q",     32'(q),       32'(m_q));
    chk("m_qv",    32'(q_valid), 32'(m_qv));
  endtask

  task automatic do_reset();
    step(1'b1, '0, '0, '0);
    step(1'b1, '0, '0, '0);
  endtask

  logic [N*DW-1:0] rnd_wd;
  logic [DW-1:0]   beat_data [MB];

  initial begin
    reset = 1'b1; req = '0; last = '0; wdata = '0;

    // Reset state
    do_reset();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_qv", 32'(q_valid), 32'h0);

    // 1: single beat from requester 1
    step(1'b0, 4'b0010, 4'b0010, 32'h0000_A500);
    chk("t1_gnt", 32'(gnt), 32'h2);
    step(1'b0, 4'b0010, 4'b0010, 32'h0000_A500);
    chk("t1_q", 32'(q), 32'hA5);
    chk("t1_qv", 32'(q_valid), 32'h1);
    chk("t1_gnt0", 32'(gnt), 32'h0);
    step(1'b0, 4'b0000, 4'b0000, 32'h0);
    chk("t1_qv0", 32'(q_valid), 32'h0);

    // 2: fairness with all requesting single beats
    do_reset();
    for (int g = 0; g < 8; g++) begin
      step(1'b0, 4'b1111, 4'b1111, 32'(g * 32'h01010101));
      chk("t2_owner", 32'(owner), 32'(g % N));
      chk("t2_gnt", 32'(gnt), 32'(1 << (g % N)));
      step(1'b0, 4'b1111, 4'b1111, 32'(g * 32'h01010101));
      chk("t2_gap", 32'(gnt), 32'h0);
    end

    // 3: burst cap on requester 2 with requester 3 waiting
    do_reset();
    step(1'b0, 4'b1100, 4'b0000, 32'h0);
    chk("t3_gnt", 32'(gnt), 32'h4);
    for (int b = 0; b < MB; b++) begin
      beat_data[b] = DW'($urandom);
      step(1'b0, 4'b1100, 4'b0000, {8'h77, beat_data[b], 16'h0});
      chk("t3_qv", 32'(q_valid), 32'h1);
      chk("t3_q", 32'(q), 32'(beat_data[b]));
    end
    chk("t3_rel", 32'(gnt), 32'h0);
    step(1'b0, 4'b1000, 4'b0000, 32'h0);
    chk("t3_qv0", 32'(q_valid), 32'h0);
    chk("t3_next", 32'(gnt), 32'h8);

    // 4: owner 1 drops req after two beats
    do_reset();
    step(1'b0, 4'b0010, 4'b0000, 32'h0);
    step(1'b0, 4'b0010, 4'b0000, 32'h0000_1100);
    step(1'b0, 4'b0010, 4'b0000, 32'h0000_2200);
    step(1'b0, 4'b0000, 4'b0000, 32'h0000_3300);
    chk("t4_gnt", 32'(gnt), 32'h0);
    chk("t4_qv", 32'(q_valid), 32'h0);
    chk("t4_q", 32'(q), 32'h22);

    // 5: reset during a beat of requester 3
    do_reset();
    step(1'b0, 4'b1000, 4'b0000, 32'h5500_0000);
    step(1'b0, 4'b1000, 4'b0000, 32'h6600_0000);
    chk("t5_q1", 32'(q), 32'h66);
    step(1'b1, 4'b1000, 4'b0000, 32'h7700_0000);
    chk("t5_gnt", 32'(gnt), 32'h0);
    chk("t5_q", 32'(q), 32'h0);
    chk("t5_qv", 32'(q_valid), 32'h0);
    chk("t5_owner", 32'(owner), 32'h0);

    // 6: simultaneous requests after reset start from index 0
    step(1'b0, 4'b1010, 4'b1010, 32'h0);
    chk("t6_first", 32'(gnt), 32'h2);
    step(1'b0, 4'b1010, 4'b1010, 32'h0);
    step(1'b0, 4'b1010, 4'b1010, 32'h0);
    chk("t6_second", 32'(gnt), 32'h8);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      rnd_wd = $urandom;
      step(($urandom_range(0, 59) == 0), N'($urandom), N'($urandom_range(0, 3) == 0 ? $urandom : 0),
           rnd_wd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
